serial_sub12: RTL and testbench

SERIAL_SUB12 -- requirements
Module: serial_sub12

---
 rtl/serial_sub12_if.sv | 15 +
 rtl/serial_sub12.sv | 90 +++++++++
 tb/tb_serial_sub12.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_sub12_if.sv
// Request/response bundle for the bit-serial 12-bit subtractor.
interface serial_sub12_if;
  localparam int unsigned OP_W  = 11;
  localparam int unsigned RES_W = 12;

  logic             start;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] out;

  modport master (output start, a, b, input busy, done, out);
  modport slave  (input start, a, b, output busy, done, out);
endinterface

// File: rtl/serial_sub12.sv
// Bit-serial signed subtractor: out = a - b, one result bit per clock
// through a single full-adder slice fed with the inverted subtrahend.
module serial_sub12 (
  input  logic          clk,
  input  logic          rst,
  serial_sub12_if.slave bus
);
  localparam int unsigned OP_W  = 11;
  localparam int unsigned RES_W = 12;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RES_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [RES_W-1:0] r_a;
  logic [RES_W-1:0] r_b;
  logic [RES_W-1:0] r_res;
  logic [RES_W-1:0] r_out;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;

  logic w_ai;
  logic w_bi_n;
  logic w_sum;
  logic w_cy;

  // Full-adder slice on the current bit; carry seeded with 1 gives a + ~b + 1
  assign w_ai   = r_a[r_cnt];
  assign w_bi_n = ~r_b[r_cnt];
  assign w_sum  = w_ai ^ w_bi_n ^ r_carry;
  assign w_cy   = (w_ai & w_bi_n) | (w_ai & r_carry) | (w_bi_n & r_carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_nx = SHIFT;
      SHIFT:   if (r_cnt == LAST_BIT) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nx != IDLE);
      r_done <= (w_state_nx == DONE);
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= {bus.a[OP_W-1], bus.a};
            r_b     <= {bus.b[OP_W-1], bus.b};
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_res   <= '0;
          end
        end
        SHIFT: begin
          r_res   <= {w_sum, r_res[RES_W-1:1]};
          r_carry <= w_cy;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) r_out <= {w_sum, r_res[RES_W-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.out  = r_out;
endmodule

// File: tb/tb_serial_sub12.sv
// Scoreboard bench for serial_sub12: issued operations queue their expected
// difference and done cycle; a negedge monitor checks every output cycle.
module tb_serial_sub12;
  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_sub12_if bus();

  serial_sub12 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;
  int          busy_lo  = -1;
  int          busy_hi  = -2;
  logic [11:0] held     = 12'h000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy window, done timing/value, and out holding between results
  always @(negedge clk) begin
    exp_t e;
    check("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    if (bus.done === 1'b1) begin
      check("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out", 32'(bus.out), 32'(e.val));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        held = e.val;
      end
    end else begin
      check("out_hold", 32'(bus.out), 32'(held));
    end
  end

  // Drive start for the current cycle and record what the DUT must produce
  task automatic issue(input logic [10:0] av, input logic [10:0] bv);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    e.val     = 12'(int'($signed(av)) - int'($signed(bv)));
    e.cyc     = cyc + 13;
    sb.push_back(e);
    busy_lo   = cyc + 1;
    busy_hi   = cyc + 13;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
      bus.a = 11'($urandom);
      bus.b = 11'($urandom);
    end
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [10:0] av, input logic [10:0] bv);
    @(posedge clk); #1;
    issue(av, bv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 11'($urandom);
    bus.b     = 11'($urandom);
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'(bus.out), 32'h000);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // Directed corner cases
    run_op(11'(5), 11'(-3));
    run_op(11'(-1024), 11'(1023));
    run_op(11'(1023), 11'(-1024));
    run_op(11'(100), 11'(100));
    run_op(11'(0), 11'(1));

    // Second start while busy must be ignored
    @(posedge clk); #1;
    issue(11'(7), 11'(2));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 11'(1);
    bus.b     = 11'(1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_drain();

    // Reset mid-operation aborts with no done pulse
    @(posedge clk); #1;
    issue(11'(300), 11'(-200));
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst     = 1'b1;
    sb.delete();
    held    = 12'h000;
    busy_lo = -1;
    busy_hi = -2;
    #1;
    check("abort_out", 32'(bus.out), 32'h000);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(11'(-4), 11'(4));

    // start held high: one result every 14 cycles
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      issue(11'(300), 11'(-45));
      repeat (14) @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    wait_drain();

    // Randomized operands with random idle gaps
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(11'($urandom), 11'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
